// File: rtl/rob_pkg.sv
// Shared types and index helpers for the multi-wide reorder buffer.
// Entry field widths follow the default register-file sizes.
package rob_pkg;
  localparam int LOG_REGS_D = 32;
  localparam int PHY_REGS_D = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW_D = idx_w(LOG_REGS_D);
  localparam int PW_D = idx_w(PHY_REGS_D);

  // n must be a power of two; the result wraps modulo n
  function automatic logic [31:0] add_mod(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] n);
    return (a + b) & (n - 32'd1);
  endfunction

  typedef struct packed {
    logic            valid;
    logic            done;
    logic            exception;
    logic [AW_D-1:0] arch_rd;
    logic [PW_D-1:0] new_prf;
    logic [PW_D-1:0] old_prf;
    logic [31:0]     pc;
    logic [31:0]     instr;
    logic            is_store;
    logic            is_branch;
  } rob_entry_t;
endpackage

// File: rtl/rob_mw_if.sv
// Dispatch, writeback, commit, recovery and status bundle of the ROB.
interface rob_mw_if import rob_pkg::*; #(
  parameter int XLEN        = 32,
  parameter int LOG_REGS    = LOG_REGS_D,
  parameter int PHY_REGS    = PHY_REGS_D,
  parameter int ROB_ENTRIES = 16,
  parameter int DISPATCH_W  = 2,
  parameter int COMMIT_W    = 2,
  parameter int CDB_PORTS   = 2
);
  localparam int IW = idx_w(ROB_ENTRIES);
  localparam int AW = idx_w(LOG_REGS);
  localparam int PW = idx_w(PHY_REGS);

  logic [DISPATCH_W-1:0]           rtrob_valid;
  logic                            rtrob_ready;
  logic [DISPATCH_W-1:0][AW-1:0]   rtrob_arch_rd;
  logic [DISPATCH_W-1:0][PW-1:0]   rtrob_new_prf;
  logic [DISPATCH_W-1:0][PW-1:0]   rtrob_old_prf;
  logic [DISPATCH_W-1:0][31:0]     rtrob_pc;
  logic [DISPATCH_W-1:0][31:0]     rtrob_instr;
  logic [DISPATCH_W-1:0]           rtrob_is_store;
  logic [DISPATCH_W-1:0]           rtrob_is_branch;
  logic [DISPATCH_W-1:0][IW-1:0]   rtrob_rob_idx;

  logic [CDB_PORTS-1:0]            cdbrob_valid;
  logic [CDB_PORTS-1:0][IW-1:0]    cdbrob_rob_idx;
  logic [CDB_PORTS-1:0][XLEN-1:0]  cdbrob_value;
  logic [CDB_PORTS-1:0]            cdbrob_exception;

  logic [COMMIT_W-1:0]             commit_valid;
  logic                            commit_ready;
  logic [COMMIT_W-1:0][AW-1:0]     commit_arch_rd;
  logic [COMMIT_W-1:0][PW-1:0]     commit_new_prf;
  logic [COMMIT_W-1:0][PW-1:0]     commit_old_prf;
  logic [COMMIT_W-1:0][31:0]       commit_pc;
  logic [COMMIT_W-1:0][31:0]       commit_instr;
  logic [COMMIT_W-1:0]             commit_is_store;
  logic [COMMIT_W-1:0]             commit_exception;

  logic                            flush_all;
  logic                            rollback_valid;
  logic [IW-1:0]                   rollback_idx;

  logic                            rob_full;
  logic                            rob_empty;
  logic [IW:0]                     rob_count;
  logic [IW-1:0]                   rob_head_idx;
  logic [IW-1:0]                   rob_tail_idx;

  modport slave (
    input  rtrob_valid, rtrob_arch_rd, rtrob_new_prf, rtrob_old_prf, rtrob_pc, rtrob_instr,
           rtrob_is_store, rtrob_is_branch, cdbrob_valid, cdbrob_rob_idx, cdbrob_value,
           cdbrob_exception, commit_ready, flush_all, rollback_valid, rollback_idx,
    output rtrob_ready, rtrob_rob_idx, commit_valid, commit_arch_rd, commit_new_prf,
           commit_old_prf, commit_pc, commit_instr, commit_is_store, commit_exception,
           rob_full, rob_empty, rob_count, rob_head_idx, rob_tail_idx
  );

  modport master (
    output rtrob_valid, rtrob_arch_rd, rtrob_new_prf, rtrob_old_prf, rtrob_pc, rtrob_instr,
           rtrob_is_store, rtrob_is_branch, cdbrob_valid, cdbrob_rob_idx, cdbrob_value,
           cdbrob_exception, commit_ready, flush_all, rollback_valid, rollback_idx,
    input  rtrob_ready, rtrob_rob_idx, commit_valid, commit_arch_rd, commit_new_prf,
           commit_old_prf, commit_pc, commit_instr, commit_is_store, commit_exception,
           rob_full, rob_empty, rob_count, rob_head_idx, rob_tail_idx
  );
endinterface

// File: rtl/rob_commit_sel.sv
// Retire lane mask: contiguous valid&done run from lane 0, an excepting
// entry may only retire alone in lane 0.
module rob_commit_sel #(
  parameter int W = 2
) (
  input  logic [W-1:0] valid,
  input  logic [W-1:0] done,
  input  logic [W-1:0] exc,
  output logic [W-1:0] mask
);
  logic [W-1:0] ok;

  for (genvar j = 0; j < W; j++) begin : g_lane
    if (j == 0) begin : g_first
      assign ok[j]   = valid[j] & done[j];
      assign mask[j] = ok[j];
    end else begin : g_rest
      // lanes above 0 never carry an exception, so only lane 0's can block them
      assign ok[j]   = valid[j] & done[j] & ~exc[j];
      assign mask[j] = (&ok[j:0]) & ~exc[0];
    end
  end
endmodule

// File: rtl/rob_mw.sv
// Multi-wide reorder buffer: in-order allocate, out-of-order writeback,
// in-order multi-lane retire, full flush and branch rollback.
module rob_mw import rob_pkg::*; #(
  parameter int ROB_ENTRIES = 16,
  parameter int DISPATCH_W  = 2,
  parameter int COMMIT_W    = 2,
  parameter int CDB_PORTS   = 2
) (
  input  logic     clk,
  input  logic     rst,
  rob_mw_if.slave  bus
);
  localparam int          IW        = idx_w(ROB_ENTRIES);
  localparam logic [IW:0] FULL_CNT  = (IW+1)'(ROB_ENTRIES);
  localparam logic [IW:0] ALLOC_MAX = (IW+1)'(ROB_ENTRIES - DISPATCH_W);

  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
    return IW'(add_mod(32'(base), 32'(off), 32'(ROB_ENTRIES)));
  endfunction

  rob_entry_t          ent     [ROB_ENTRIES];
  rob_entry_t          ent_nxt [ROB_ENTRIES];
  logic [IW-1:0]       head, tail, head_nxt, tail_nxt, rb_dist;
  logic [IW:0]         count, count_nxt, n_alloc, n_commit;
  logic [IW-1:0]       hidx [COMMIT_W];
  logic [COMMIT_W-1:0] hv, hd, hx, cv;
  logic                ready, rb_take;
  logic                unused_value;

  assign unused_value = ^bus.cdbrob_value;

  // free space is judged on registered count only; same-cycle retire does not help
  assign ready            = count <= ALLOC_MAX;
  assign bus.rtrob_ready  = ready;
  assign bus.rob_full     = count == FULL_CNT;
  assign bus.rob_empty    = count == '0;
  assign bus.rob_count    = count;
  assign bus.rob_head_idx = head;
  assign bus.rob_tail_idx = tail;

  for (genvar k = 0; k < DISPATCH_W; k++) begin : g_tag
    assign bus.rtrob_rob_idx[k] = wrap(tail, k);
  end

  always_comb begin
    for (int j = 0; j < COMMIT_W; j++) begin
      hidx[j] = wrap(head, j);
      hv[j]   = ent[hidx[j]].valid;
      hd[j]   = ent[hidx[j]].done;
      hx[j]   = ent[hidx[j]].exception;
    end
  end

  rob_commit_sel #(.W(COMMIT_W)) u_sel (.valid(hv), .done(hd), .exc(hx), .mask(cv));

  assign bus.commit_valid = cv;

  for (genvar j = 0; j < COMMIT_W; j++) begin : g_cmt
    assign bus.commit_arch_rd[j]   = cv[j] ? ent[hidx[j]].arch_rd   : '0;
    assign bus.commit_new_prf[j]   = cv[j] ? ent[hidx[j]].new_prf   : '0;
    assign bus.commit_old_prf[j]   = cv[j] ? ent[hidx[j]].old_prf   : '0;
    assign bus.commit_pc[j]        = cv[j] ? ent[hidx[j]].pc        : '0;
    assign bus.commit_instr[j]     = cv[j] ? ent[hidx[j]].instr     : '0;
    assign bus.commit_is_store[j]  = cv[j] & ent[hidx[j]].is_store;
    assign bus.commit_exception[j] = cv[j] & ent[hidx[j]].exception;
  end

  assign rb_take = bus.rollback_valid & ent[bus.rollback_idx].valid;
  assign rb_dist = bus.rollback_idx - head;

  always_comb begin
    n_alloc  = '0;
    n_commit = '0;
    for (int k = 0; k < DISPATCH_W; k++)
      if (bus.rtrob_valid[k]) n_alloc = n_alloc + 1'b1;
    if (!ready || rb_take) n_alloc = '0;
    for (int j = 0; j < COMMIT_W; j++)
      if (cv[j]) n_commit = n_commit + 1'b1;
    if (!bus.commit_ready) n_commit = '0;

    ent_nxt = ent;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (bus.cdbrob_valid[p] && ent[bus.cdbrob_rob_idx[p]].valid) begin
        ent_nxt[bus.cdbrob_rob_idx[p]].done      = 1'b1;
        ent_nxt[bus.cdbrob_rob_idx[p]].exception = ent_nxt[bus.cdbrob_rob_idx[p]].exception
                                                   | bus.cdbrob_exception[p];
      end
    end
    if (ready && !rb_take) begin
      for (int k = 0; k < DISPATCH_W; k++) begin
        if (bus.rtrob_valid[k])
          ent_nxt[wrap(tail, k)] = '{valid: 1'b1, done: 1'b0, exception: 1'b0,
                                     arch_rd: bus.rtrob_arch_rd[k],
                                     new_prf: bus.rtrob_new_prf[k],
                                     old_prf: bus.rtrob_old_prf[k],
                                     pc: bus.rtrob_pc[k], instr: bus.rtrob_instr[k],
                                     is_store: bus.rtrob_is_store[k],
                                     is_branch: bus.rtrob_is_branch[k]};
      end
    end
    if (bus.commit_ready) begin
      for (int j = 0; j < COMMIT_W; j++)
        if (cv[j]) ent_nxt[hidx[j]] = '0;
    end
    // anything further from head than the mispredicted branch is younger
    if (rb_take) begin
      for (int i = 0; i < ROB_ENTRIES; i++)
        if (IW'(IW'(i) - head) > rb_dist) ent_nxt[i] = '0;
    end

    head_nxt = wrap(head, int'(n_commit));
    if (rb_take) begin
      tail_nxt  = wrap(bus.rollback_idx, 1);
      count_nxt = (IW+1)'(rb_dist) + (IW+1)'(1) - n_commit;
    end else begin
      tail_nxt  = wrap(tail, int'(n_alloc));
      count_nxt = count + n_alloc - n_commit;
    end

    if (bus.flush_all) begin
      for (int i = 0; i < ROB_ENTRIES; i++) ent_nxt[i] = '0;
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_ENTRIES; i++) ent[i] <= '0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
      ent   <= ent_nxt;
    end
  end
endmodule

// File: tb/tb_rob_mw.sv
// Directed bench for rob_mw with an 8-entry, 2-wide configuration.
module tb_rob_mw;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rob_mw_if #(.ROB_ENTRIES(8), .DISPATCH_W(2), .COMMIT_W(2), .CDB_PORTS(2)) bus ();

  rob_mw #(.ROB_ENTRIES(8), .DISPATCH_W(2), .COMMIT_W(2), .CDB_PORTS(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // tag t carries arch_rd t+1+rd_off, pc 0x1000+4t
  task automatic alloc(input int n, input int tag0, input int rd_off);
    for (int k = 0; k < 2; k++) begin
      int t;
      t = (tag0 + k) % 8;
      bus.rtrob_valid[k]     = (k < n);
      bus.rtrob_arch_rd[k]   = 5'(t + 1 + rd_off);
      bus.rtrob_new_prf[k]   = 6'(32 + t);
      bus.rtrob_old_prf[k]   = 6'(t);
      bus.rtrob_pc[k]        = 32'h1000 + 32'(t * 4);
      bus.rtrob_instr[k]     = 32'h13 + 32'(t);
      bus.rtrob_is_store[k]  = 1'b0;
      bus.rtrob_is_branch[k] = 1'b0;
    end
  endtask

  task automatic cdb(input logic v0, input int i0, input logic x0,
                     input logic v1, input int i1, input logic x1);
    bus.cdbrob_valid       = {v1, v0};
    bus.cdbrob_rob_idx[0]  = 3'(i0);
    bus.cdbrob_rob_idx[1]  = 3'(i1);
    bus.cdbrob_exception   = {x1, x0};
    bus.cdbrob_value[0]    = 32'hdead_0000 + 32'(i0);
    bus.cdbrob_value[1]    = 32'hdead_0000 + 32'(i1);
  endtask

  // one clock; pulse-type inputs drop right after the edge
  task automatic step();
    @(posedge clk);
    #1;
    bus.rtrob_valid    = '0;
    bus.cdbrob_valid   = '0;
    bus.flush_all      = 1'b0;
    bus.rollback_valid = 1'b0;
  endtask

  initial begin
    bus.rtrob_valid = '0; bus.rtrob_arch_rd = '0; bus.rtrob_new_prf = '0;
    bus.rtrob_old_prf = '0; bus.rtrob_pc = '0; bus.rtrob_instr = '0;
    bus.rtrob_is_store = '0; bus.rtrob_is_branch = '0;
    bus.cdbrob_valid = '0; bus.cdbrob_rob_idx = '0; bus.cdbrob_value = '0;
    bus.cdbrob_exception = '0; bus.commit_ready = 1'b0;
    bus.flush_all = 1'b0; bus.rollback_valid = 1'b0; bus.rollback_idx = '0;

    #1;
    chk("rst_count", bus.rob_count, 0);
    chk("rst_empty", bus.rob_empty, 1);
    chk("rst_full", bus.rob_full, 0);
    chk("rst_ready", bus.rtrob_ready, 1);
    chk("rst_cvalid", bus.commit_valid, 0);
    chk("rst_crd", bus.commit_arch_rd, 0);
    chk("rst_cpc", bus.commit_pc, 0);
    chk("rst_tags", bus.rtrob_rob_idx, {3'd1, 3'd0});
    #1 rst = 1'b1;

    // dual allocate, out-of-order completion
    alloc(2, 0, 0); step();
    chk("a1_tail", bus.rob_tail_idx, 2);
    chk("a1_tags", bus.rtrob_rob_idx, {3'd3, 3'd2});
    alloc(2, 2, 0); step();
    chk("a2_count", bus.rob_count, 4);
    cdb(1, 3, 0, 1, 1, 0); step();
    chk("ooo_cvalid_none", bus.commit_valid, 2'b00);
    cdb(1, 0, 0, 0, 0, 0); step();
    chk("ooo_cvalid", bus.commit_valid, 2'b11);
    chk("ooo_crd", bus.commit_arch_rd, {5'd2, 5'd1});
    chk("ooo_cpc", bus.commit_pc, {32'h1004, 32'h1000});
    bus.commit_ready = 1'b1; step();
    chk("pop_head", bus.rob_head_idx, 2);
    chk("pop_count", bus.rob_count, 2);
    chk("wait_tag2", bus.commit_valid, 2'b00);
    chk("wait_crd", bus.commit_arch_rd, 0);
    cdb(1, 2, 0, 0, 0, 0); step();
    chk("tag2_cvalid", bus.commit_valid, 2'b11);
    chk("tag2_crd", bus.commit_arch_rd, {5'd4, 5'd3});
    step();
    chk("drain_head", bus.rob_head_idx, 4);
    chk("drain_empty", bus.rob_empty, 1);
    bus.commit_ready = 1'b0;

    // exception isolation on tags 4,5
    alloc(2, 4, 0); step();
    cdb(1, 4, 0, 1, 5, 1); step();
    chk("exc_first", bus.commit_valid, 2'b01);
    chk("exc_first_x", bus.commit_exception, 2'b00);
    bus.commit_ready = 1'b1; step();
    chk("exc_alone", bus.commit_valid, 2'b01);
    chk("exc_alone_x", bus.commit_exception, 2'b01);
    chk("exc_alone_rd", bus.commit_arch_rd, {5'd0, 5'd6});
    step();
    chk("exc_count", bus.rob_count, 0);
    chk("exc_head", bus.rob_head_idx, 6);
    bus.commit_ready = 1'b0;

    // flush outranks allocate, writeback and rollback
    alloc(2, 6, 0); step();
    chk("wrap_tail0", bus.rob_tail_idx, 0);
    alloc(2, 0, 0); step();
    chk("pre_flush_cnt", bus.rob_count, 4);
    alloc(2, 2, 0); cdb(1, 6, 0, 0, 0, 0);
    bus.rollback_valid = 1'b1; bus.rollback_idx = 3'd6; bus.flush_all = 1'b1;
    step();
    chk("flush_count", bus.rob_count, 0);
    chk("flush_empty", bus.rob_empty, 1);
    chk("flush_head", bus.rob_head_idx, 0);
    chk("flush_tail", bus.rob_tail_idx, 0);
    chk("flush_cvalid", bus.commit_valid, 0);

    // full and wrap
    for (int s = 0; s < 4; s++) begin
      alloc(2, 2 * s, 0); step();
    end
    chk("full_ready", bus.rtrob_ready, 0);
    chk("full_full", bus.rob_full, 1);
    chk("full_count", bus.rob_count, 8);
    alloc(2, 0, 0); step();
    chk("full_drop_tail", bus.rob_tail_idx, 0);
    cdb(1, 0, 0, 1, 1, 0); step();
    chk("full_cvalid", bus.commit_valid, 2'b11);
    bus.commit_ready = 1'b1; alloc(2, 0, 0); step();
    chk("same_cyc_count", bus.rob_count, 6);
    chk("same_cyc_head", bus.rob_head_idx, 2);
    chk("same_cyc_tail", bus.rob_tail_idx, 0);
    bus.commit_ready = 1'b0;
    chk("reuse_tags", bus.rtrob_rob_idx, {3'd1, 3'd0});
    alloc(2, 0, 19); step();
    chk("reuse_tail", bus.rob_tail_idx, 2);
    chk("reuse_count", bus.rob_count, 8);

    // rollback to tag 2 with a same-cycle allocate
    bus.flush_all = 1'b1; step();
    for (int s = 0; s < 3; s++) begin
      alloc(2, 2 * s, 0); step();
    end
    chk("rb_pre_count", bus.rob_count, 6);
    alloc(2, 6, 0); bus.rollback_valid = 1'b1; bus.rollback_idx = 3'd2; step();
    chk("rb_tail", bus.rob_tail_idx, 3);
    chk("rb_count", bus.rob_count, 3);
    chk("rb_tags", bus.rtrob_rob_idx, {3'd4, 3'd3});
    cdb(1, 4, 0, 1, 0, 0); step();
    chk("rb_late_count", bus.rob_count, 3);
    chk("rb_late_tail", bus.rob_tail_idx, 3);
    chk("rb_cvalid", bus.commit_valid, 2'b01);
    chk("rb_crd", bus.commit_arch_rd, {5'd0, 5'd1});

    // asynchronous reset between edges
    alloc(2, 3, 0); step();
    chk("ar_pre_count", bus.rob_count, 5);
    #2 rst = 1'b0;
    #1;
    chk("ar_count", bus.rob_count, 0);
    chk("ar_empty", bus.rob_empty, 1);
    chk("ar_ready", bus.rtrob_ready, 1);
    chk("ar_head", bus.rob_head_idx, 0);
    chk("ar_tail", bus.rob_tail_idx, 0);
    chk("ar_cvalid", bus.commit_valid, 0);
    chk("ar_crd", bus.commit_arch_rd, 0);
    #3 rst = 1'b1;
    step();
    chk("ar_hold", bus.rob_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rob_mw.md
# rob_mw

Multi-wide reorder buffer for the out-of-order core. It sits between rename/dispatch and the commit/retire stage. Each cycle it:
- allocates up to DISPATCH_W µops in program order;
- accepts out-of-order completion from CDB_PORTS result buses;
- retires up to COMMIT_W consecutive completed entries in order.

It supports full flush and partial rollback to a mispredicted branch tag. Values live in the PRF; the ROB holds bookkeeping only.

## Interface
- XLEN, 32, datapath width (sizes `cdbrob_value`, which is accepted and not stored)
- LOG_REGS, 32, architectural registers
- PHY_REGS, 64, physical registers
- ROB_ENTRIES, 16, entries; must be a power of 2 and ≥ 2·DISPATCH_W
- DISPATCH_W, 2, allocation lanes
- COMMIT_W, 2, retire lanes
- CDB_PORTS, 2, writeback ports
- IW = $clog2(ROB_ENTRIES), AW = $clog2(LOG_REGS), PW = $clog2(PHY_REGS)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rtrob_valid  in  [DISPATCH_W]  per-lane allocate request; set lanes must be contiguous from lane 0
- rtrob_ready  out  1  free entries ≥ DISPATCH_W
- rtrob_arch_rd / rtrob_new_prf / rtrob_old_prf  in  [DISPATCH_W][AW/PW/PW]  rename info
- rtrob_pc, rtrob_instr  in  [DISPATCH_W][32]
- rtrob_is_store, rtrob_is_branch  in  [DISPATCH_W]
- rtrob_rob_idx  out  [DISPATCH_W][IW]  tag for each lane; equals tail+lane
- cdbrob_valid  in  [CDB_PORTS]
- cdbrob_rob_idx  in  [CDB_PORTS][IW]
- cdbrob_value  in  [CDB_PORTS][XLEN]  accepted, not stored
- cdbrob_exception  in  [CDB_PORTS]
- commit_valid  out  [COMMIT_W]  contiguous mask of retirable head entries
- commit_ready  in  1  all presented lanes pop this cycle
- commit_arch_rd / commit_new_prf / commit_old_prf / commit_pc / commit_instr / commit_is_store / commit_exception  out  [COMMIT_W]  entry fields
- flush_all  in  1  discard every entry
- rollback_valid  in  1  discard all entries younger than rollback_idx
- rollback_idx  in  [IW]  tag of the mispredicted branch
- rob_full, rob_empty  out  1 each
- rob_count  out  [IW+1]
- rob_head_idx, rob_tail_idx  out  [IW] each

## Operation
Storage:
- Each entry holds: valid, done, exception, arch_rd, new_prf, old_prf, pc, instr, is_store, is_branch.
- head, tail: IW bits, wrapping mod ROB_ENTRIES.
- count: IW+1 bits, 0..ROB_ENTRIES.

Allocation:
- When rtrob_ready is high, each valid lane k writes entry tail+k, sets valid=1 and done=0.
- tail += popcount(rtrob_valid).
- Valid lanes while rtrob_ready=0 are ignored, all-or-nothing.

Writeback:
- Each valid CDB port sets done=1 on its entry and ORs cdbrob_exception into the entry.
- Writebacks to an invalid entry are ignored.
- Two ports hitting the same index is legal; the result is the OR of both.

Commit:
- Lane j is valid iff entry head+j is valid and done, lanes 0..j-1 are valid, and no lane <j carries an exception.
- An excepting entry is presented only in lane 0, alone.
- On commit_ready, committed entries are cleared, head advances by popcount(commit_valid), and count updates.
- The ROB never self-flushes on an exception; the backend drives flush_all.

Rollback:
- tail := rollback_idx+1.
- Entries rollback_idx+1 .. old tail-1 are cleared.
- count := distance(head, rollback_idx)+1, less any lanes committing this cycle.
- If rollback_idx is not a valid entry, the rollback is ignored.

Priority, highest first:
1. reset
2. flush_all: all entries invalid, head=tail=count=0
3. rollback: suppresses same-cycle allocation; commit still proceeds
4. normal allocate/writeback/commit

Count rule: next count = count + n_alloc − n_commit, both applied in the same cycle.

## Timing
- Reset values:
  - head = tail = count = 0
  - all entries valid = 0
  - rob_empty = 1, rob_full = 0, rtrob_ready = 1
  - commit_valid = 0, all commit_* fields = 0
- rtrob_rob_idx, commit_* and status outputs are combinational from registered state. There is no input→output combinational path, except commit_valid, which does not depend on commit_ready.
- Writeback→retire latency is 1 cycle: done is registered, and a CDB write at edge N makes commit_valid visible after edge N.
- Allocation at edge N makes an entry eligible for writeback from cycle N+1.
- Wrap-around: lanes index mod ROB_ENTRIES, so tail=ROB_ENTRIES−1 with 2 lanes writes entries 15 and 0.
- Full: count = ROB_ENTRIES.
  - Commit and allocate in the same cycle do not count as free space; rtrob_ready uses registered count only.

## Structure
- Package rob_pkg holds:
  - rob_entry_t struct
  - a parameter-derived width helper
  - an add_mod function for index arithmetic
- Sub-module rob_commit_sel: combinational lane-mask generator giving contiguous done/valid and the exception-alone rule. It is verified standalone.

## Test plan
All scenarios use ROB_ENTRIES=8 and DISPATCH_W = COMMIT_W = CDB_PORTS = 2.

- Dual allocate, out-of-order completion:
  - Stimulus: allocate 4 entries (tags 0..3), CDB tags 3 and 1, then tag 0.
  - Required: commit_valid=2'b11 with rd fields of tags 0,1, then nothing until tag 2 is done.
- Exception isolation:
  - Stimulus: tags 0,1 done, tag 1 with exception.
  - Required: cycle 1 commit_valid=01 (tag 0); next cycle commit_valid=01 with commit_exception=1 for tag 1.
- Full and wrap:
  - Stimulus: fill 8 entries.
  - Required: rtrob_ready=0, rob_full=1.
  - Stimulus: then commit 2 and allocate 2.
  - Required: tags 0,1 reused; tail wraps to 2; count=8.
- Rollback:
  - Stimulus: 6 entries, rollback_idx=2 with simultaneous allocate.
  - Required: tail=3, count=3, the allocation is dropped, and late CDB writes to tag 4 are ignored.
- Flush priority:
  - Stimulus: flush_all with allocate, CDB and rollback all asserted.
  - Required: next cycle count=0, rob_empty=1, head=tail=0.
- Async reset mid-operation:
  - Stimulus: rst low between edges with 5 entries live.
  - Required: outputs reach reset values immediately, without waiting for clk.
